// File: rtl/axi_wr_burst_gen_pkg.sv
// Shared types and width defaults for the AXI write-burst generator.
// Optional per-ID outstanding tracking is enabled by AXI_WR_BURST_GEN_ID_TRACK_EN.
package axi_wr_burst_gen_pkg;

    localparam int unsigned PID_WIDTH     = 4;
    localparam int unsigned PADDR_WIDTH   = 32;
    localparam int unsigned PLENGTH_WIDTH = 4;
    localparam int unsigned PDATA_WIDTH   = 32;
    localparam int unsigned PAWUSER_WIDTH = 2;

    typedef enum logic [PAWUSER_WIDTH-1:0] {
        REGULAR,
        DIVERT,
        BLOCK
    } burst_type_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } gen_state_t;

    localparam logic [1:0] OKAY = 2'b00;

endpackage

// File: rtl/axi_wr_burst_gen_if.sv
// AW/W/B channel bundle between the burst generator (master) and its sink (slave).
interface axi_wr_burst_gen_if
    import axi_wr_burst_gen_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = PID_WIDTH,
    parameter int unsigned ADDR_WIDTH = PADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = PLENGTH_WIDTH,
    parameter int unsigned DATA_WIDTH = PDATA_WIDTH,
    parameter int unsigned USER_WIDTH = PAWUSER_WIDTH
) ();

    logic                    awvalid;
    logic                    awready;
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [LEN_WIDTH-1:0]    awlen;
    logic [2:0]              awsize;
    logic [USER_WIDTH-1:0]   awuser;

    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awuser,
        input  awready,
        output wvalid, wid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awuser,
        output awready,
        input  wvalid, wid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready
    );

endinterface

// File: rtl/axi_wr_resp_tracker.sv
// B-channel collector: outstanding/done counters, sticky error and, when
// AXI_WR_BURST_GEN_ID_TRACK_EN is defined, per-ID outstanding counters.
module axi_wr_resp_tracker
    import axi_wr_burst_gen_pkg::*;
`ifdef AXI_WR_BURST_GEN_ID_TRACK_EN
#(
    parameter int unsigned ID_WIDTH = PID_WIDTH
)
`endif
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wlast_hs,
    input  logic                   bvalid,
    input  logic [1:0]             bresp,
    output logic                   bready,
    output logic [7:0]             outst_cnt,
    output logic [15:0]            done_cnt,
    output logic                   err
`ifdef AXI_WR_BURST_GEN_ID_TRACK_EN
    ,
    input  logic [ID_WIDTH-1:0]    wid,
    input  logic [ID_WIDTH-1:0]    bid,
    output logic [2**ID_WIDTH-1:0] id_busy
`endif
);

    logic        bready_q;
    logic [7:0]  outst_q;
    logic [15:0] done_q;
    logic        err_q;
    logic        b_hs;
    logic        b_ok;

    assign b_hs = bvalid && bready_q;

`ifdef AXI_WR_BURST_GEN_ID_TRACK_EN
    logic [7:0] id_cnt_q [2**ID_WIDTH];

    // A B is only consumed if both the global and its own ID counter have something pending.
    assign b_ok = b_hs && (outst_q != 8'd0) && (id_cnt_q[bid] != 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ID_WIDTH; i++) id_cnt_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 2**ID_WIDTH; i++) begin
                id_cnt_q[i] <= id_cnt_q[i]
                             + {7'd0, wlast_hs && (wid == ID_WIDTH'(i))}
                             - {7'd0, b_ok && (bid == ID_WIDTH'(i))};
            end
        end
    end

    always_comb begin
        id_busy = '0;
        for (int i = 0; i < 2**ID_WIDTH; i++) id_busy[i] = (id_cnt_q[i] != 8'd0);
    end
`else
    assign b_ok = b_hs && (outst_q != 8'd0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bready_q <= 1'b0;
            outst_q  <= 8'd0;
            done_q   <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            bready_q <= 1'b1;
            outst_q  <= outst_q + {7'd0, wlast_hs} - {7'd0, b_ok};
            if (b_ok) done_q <= done_q + 16'd1;
            // Unexpected B or non-OKAY response; error responses are still counted.
            if (b_hs && (!b_ok || (bresp != OKAY))) err_q <= 1'b1;
        end
    end

    assign bready    = bready_q;
    assign outst_cnt = outst_q;
    assign done_cnt  = done_q;
    assign err       = err_q;

endmodule

// File: rtl/axi_wr_burst_gen.sv
// AXI write-burst master: one command at a time, AW then W beats, B tracked downstream.
// Define AXI_WR_BURST_GEN_ID_TRACK_EN to add per-ID tracking and the id_busy output.
module axi_wr_burst_gen
    import axi_wr_burst_gen_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = PID_WIDTH,
    parameter int unsigned ADDR_WIDTH = PADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = PLENGTH_WIDTH,
    parameter int unsigned DATA_WIDTH = PDATA_WIDTH,
    parameter int unsigned USER_WIDTH = PAWUSER_WIDTH,
    parameter int unsigned MAX_OUTST  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ID_WIDTH-1:0]    cmd_id,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    input  logic [USER_WIDTH-1:0]  cmd_user,
    input  logic [DATA_WIDTH-1:0]  cmd_seed,
    axi_wr_burst_gen_if.master     axi,
    output logic [7:0]             outst_cnt,
    output logic [15:0]            done_cnt,
    output logic                   err
`ifdef AXI_WR_BURST_GEN_ID_TRACK_EN
    ,
    output logic [2**ID_WIDTH-1:0] id_busy
`endif
);

    localparam logic [LEN_WIDTH-1:0] BEAT_ONE = LEN_WIDTH'(1);

    gen_state_t            state_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [USER_WIDTH-1:0] user_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [LEN_WIDTH-1:0]  beat_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  wlast_q;
    logic                  wlast_hs;

    assign cmd_ready = (state_q == IDLE) && (outst_cnt < 8'(MAX_OUTST));
    assign wlast_hs  = wvalid_q && axi.wready && wlast_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            user_q    <= '0;
            seed_q    <= '0;
            beat_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        id_q      <= cmd_id;
                        addr_q    <= cmd_addr;
                        len_q     <= cmd_len;
                        user_q    <= cmd_user;
                        seed_q    <= cmd_seed;
                        beat_q    <= '0;
                        awvalid_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (axi.awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= (len_q == '0);
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (axi.wready) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            beat_q  <= beat_q + BEAT_ONE;
                            wlast_q <= ((beat_q + BEAT_ONE) == len_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign axi.awvalid = awvalid_q;
    assign axi.awid    = id_q;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = len_q;
    assign axi.awuser  = user_q;
    assign axi.awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign axi.wvalid  = wvalid_q;
    assign axi.wid     = id_q;
    assign axi.wdata   = seed_q + DATA_WIDTH'(beat_q) + DATA_WIDTH'(1);
    assign axi.wstrb   = '1;
    assign axi.wlast   = wlast_q;

    axi_wr_resp_tracker
`ifdef AXI_WR_BURST_GEN_ID_TRACK_EN
    #(
        .ID_WIDTH (ID_WIDTH)
    )
`endif
    u_resp_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .wlast_hs  (wlast_hs),
        .bvalid    (axi.bvalid),
        .bresp     (axi.bresp),
        .bready    (axi.bready),
        .outst_cnt (outst_cnt),
        .done_cnt  (done_cnt),
        .err       (err)
`ifdef AXI_WR_BURST_GEN_ID_TRACK_EN
        ,
        .wid       (id_q),
        .bid       (axi.bid),
        .id_busy   (id_busy)
`endif
    );

endmodule

// File: tb/tb_axi_wr_burst_gen.sv
// Bench for axi_wr_burst_gen: transaction-level queue model checked every cycle plus literals.
module tb_axi_wr_burst_gen;
    import axi_wr_burst_gen_pkg::*;

    localparam int unsigned IDW = 4, AW = 32, LW = 4, DW = 32, UW = 2, MAXO = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [IDW-1:0] cmd_id = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [UW-1:0] cmd_user = '0;
    logic [DW-1:0] cmd_seed = '0;
    logic [7:0]    outst_cnt;
    logic [15:0]   done_cnt;
    logic          err;
`ifdef AXI_WR_BURST_GEN_ID_TRACK_EN
    logic [2**IDW-1:0] id_busy;
`endif

    axi_wr_burst_gen_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
                          .DATA_WIDTH(DW), .USER_WIDTH(UW)) bus ();

    axi_wr_burst_gen #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW),
                       .USER_WIDTH(UW), .MAX_OUTST(MAXO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_id    (cmd_id),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_user  (cmd_user),
        .cmd_seed  (cmd_seed),
        .axi       (bus),
        .outst_cnt (outst_cnt),
        .done_cnt  (done_cnt),
        .err       (err)
`ifdef AXI_WR_BURST_GEN_ID_TRACK_EN
        ,
        .id_busy   (id_busy)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Sink-side ready generation: optional AW delay and W toggling.
    int aw_delay = 0;
    bit w_toggle = 1'b0;
    int aw_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (bus.awvalid) aw_cnt++;
        else aw_cnt = 0;
        bus.awready = (aw_delay == 0) || (aw_cnt > aw_delay);
        bus.wready  = w_toggle ? ~bus.wready : 1'b1;
    end

    // Transaction-level model.
    typedef struct {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [LW-1:0]  len;
        logic [UW-1:0]  user;
        logic [DW-1:0]  seed;
    } aw_t;
    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic           last;
    } w_t;

    aw_t         awq[$];
    w_t          wq[$];
    logic [DW-1:0] wlog[$];
    logic        llog[$];
    int          m_outst = 0;
    logic [15:0] m_done = '0;
    logic        m_err = 1'b0;
    int          m_idcnt[2**IDW];
    int          cyc = 0, since_rst = 0, acc_cnt = 0, acc_cyc = 0, aw_first_cyc = 0;
    bit          aw_prev = 1'b0;

    always @(negedge clk) begin
        bit  exp_ready, last, acc;
        w_t  b;
        aw_t a;
        cyc++;
        if (!rst_n) begin
            awq.delete();
            wq.delete();
            m_outst = 0;
            m_done  = '0;
            m_err   = 1'b0;
            for (int i = 0; i < 2**IDW; i++) m_idcnt[i] = 0;
            since_rst = 0;
            aw_prev = 1'b0;
        end else begin
            exp_ready = (awq.size() == 0) && (wq.size() == 0) && (m_outst < MAXO);
            chk("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
            chk("awvalid", 64'(bus.awvalid), 64'(awq.size() != 0));
            if (bus.awvalid && awq.size() != 0) begin
                chk("awid", 64'(bus.awid), 64'(awq[0].id));
                chk("awaddr", 64'(bus.awaddr), 64'(awq[0].addr));
                chk("awlen", 64'(bus.awlen), 64'(awq[0].len));
                chk("awuser", 64'(bus.awuser), 64'(awq[0].user));
                chk("awsize", 64'(bus.awsize), 64'd2);
            end
            chk("wvalid", 64'(bus.wvalid), 64'(wq.size() != 0));
            if (bus.wvalid && wq.size() != 0) begin
                chk("wid", 64'(bus.wid), 64'(wq[0].id));
                chk("wdata", 64'(bus.wdata), 64'(wq[0].data));
                chk("wlast", 64'(bus.wlast), 64'(wq[0].last));
                chk("wstrb", 64'(bus.wstrb), 64'hF);
            end else begin
                chk("wlast_idle", 64'(bus.wlast), 64'd0);
            end
            chk("outst_cnt", 64'(outst_cnt), 64'(m_outst));
            chk("done_cnt", 64'(done_cnt), 64'(m_done));
            chk("err", 64'(err), 64'(m_err));
            if (since_rst > 0) chk("bready", 64'(bus.bready), 64'd1);
`ifdef AXI_WR_BURST_GEN_ID_TRACK_EN
            begin
                logic [2**IDW-1:0] exp_busy;
                for (int i = 0; i < 2**IDW; i++) exp_busy[i] = (m_idcnt[i] != 0);
                chk("id_busy", 64'(id_busy), 64'(exp_busy));
            end
`endif
            since_rst++;
            if (bus.awvalid && !aw_prev) aw_first_cyc = cyc;
            aw_prev = bus.awvalid;

            // Predict the handshakes of the coming edge.
            last = 1'b0;
            acc  = 1'b0;
            b    = '{id: '0, data: '0, last: 1'b0};
            if (bus.wvalid && bus.wready && wq.size() != 0) begin
                b = wq.pop_front();
                wlog.push_back(bus.wdata);
                llog.push_back(bus.wlast);
                last = b.last;
            end
            if (bus.awvalid && bus.awready && awq.size() != 0) begin
                a = awq.pop_front();
                for (int k = 0; k <= int'(a.len); k++)
                    wq.push_back('{id: a.id, data: a.seed + DW'(k) + DW'(1), last: (k == int'(a.len))});
            end
            if (cmd_valid && exp_ready) begin
                awq.push_back('{id: cmd_id, addr: cmd_addr, len: cmd_len, user: cmd_user,
                                seed: cmd_seed});
                acc_cnt++;
                acc_cyc = cyc;
            end
            if (bus.bvalid && bus.bready) begin
                acc = (m_outst > 0);
`ifdef AXI_WR_BURST_GEN_ID_TRACK_EN
                acc = acc && (m_idcnt[bus.bid] > 0);
`endif
                if (!acc || bus.bresp != 2'b00) m_err = 1'b1;
            end
            m_outst = m_outst + int'(last) - int'(acc);
            if (acc) m_done = m_done + 16'd1;
`ifdef AXI_WR_BURST_GEN_ID_TRACK_EN
            if (last) m_idcnt[b.id]++;
            if (acc) m_idcnt[bus.bid]--;
`endif
        end
    end

    int cmd_start = 0;

    task automatic drive_cmd(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                             input logic [LW-1:0] len, input logic [UW-1:0] user,
                             input logic [DW-1:0] seed);
        cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_user = user; cmd_seed = seed;
        cmd_start = acc_cnt;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 300 && acc_cnt == cmd_start; i++) begin
            @(negedge clk);
            #2;
        end
        chk("cmd_accept_timeout", 64'(acc_cnt != cmd_start), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic issue_cmd(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                             input logic [LW-1:0] len, input logic [UW-1:0] user,
                             input logic [DW-1:0] seed);
        drive_cmd(id, addr, len, user, seed);
        wait_accept();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (awq.size() != 0 || wq.size() != 0); i++) @(posedge clk);
        #1;
        chk("idle_timeout", 64'(awq.size() != 0 || wq.size() != 0), 64'd0);
    endtask

    task automatic send_b(input logic [IDW-1:0] id, input logic [1:0] resp);
        bus.bid = id;
        bus.bresp = resp;
        bus.bvalid = 1'b1;
        @(posedge clk);
        #1;
        bus.bvalid = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_awvalid", 64'(bus.awvalid), 64'd0);
        chk("rst_wvalid", 64'(bus.wvalid), 64'd0);
        chk("rst_wlast", 64'(bus.wlast), 64'd0);
        chk("rst_awaddr", 64'(bus.awaddr), 64'd0);
        chk("rst_awid", 64'(bus.awid), 64'd0);
        chk("rst_outst", 64'(outst_cnt), 64'd0);
        chk("rst_done", 64'(done_cnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_bready", 64'(bus.bready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base;
        bus.bvalid = 1'b0;
        bus.bid = '0;
        bus.bresp = 2'b00;
        rst_n = 1'b0;
        apply_reset();

        // Burst of 4, no backpressure.
        base = wlog.size();
        issue_cmd(4'd1, 32'd1, 4'd3, REGULAR, 32'd1);
        wait_idle();
        chk("t1_beats", 64'(wlog.size() - base), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_wdata", 64'(wlog[base+i]), 64'(i + 2));
            chk("t1_wlast", 64'(llog[base+i]), 64'(i == 3));
        end
        chk("t1_aw_latency", 64'(aw_first_cyc - acc_cyc), 64'd1);
        chk("t1_outst", 64'(outst_cnt), 64'd1);
        send_b(4'd1, 2'b00);
        chk("t1_outst_after_b", 64'(outst_cnt), 64'd0);
        chk("t1_done", 64'(done_cnt), 64'd1);
        chk("t1_err", 64'(err), 64'd0);

        // Same burst under AW delay and W toggling.
        aw_delay = 3;
        w_toggle = 1'b1;
        base = wlog.size();
        issue_cmd(4'd1, 32'd1, 4'd3, REGULAR, 32'd1);
        wait_idle();
        chk("t2_beats", 64'(wlog.size() - base), 64'd4);
        chk("t2_last_data", 64'(wlog[base+3]), 64'd5);
        send_b(4'd1, 2'b00);
        aw_delay = 0;
        w_toggle = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Outstanding limit of 2 and a B coinciding with a wlast handshake.
        issue_cmd(4'd2, 32'h100, 4'd0, DIVERT, 32'h10);
        wait_idle();
        chk("t3_outst1", 64'(outst_cnt), 64'd1);
        issue_cmd(4'd3, 32'h200, 4'd1, REGULAR, 32'h20);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        send_b(4'd2, 2'b00);
        wait_idle();
        chk("t3_coincide_outst", 64'(outst_cnt), 64'd1);
        chk("t3_coincide_done", 64'(done_cnt), 64'd3);
        issue_cmd(4'd4, 32'h300, 4'd0, BLOCK, 32'h30);
        wait_idle();
        chk("t3_full_outst", 64'(outst_cnt), 64'd2);
        drive_cmd(4'd5, 32'h400, 4'd0, REGULAR, 32'h40);
        repeat (4) @(posedge clk);
        #1;
        chk("t3_full_ready", 64'(cmd_ready), 64'd0);
        chk("t3_full_not_acc", 64'(acc_cnt == cmd_start), 64'd1);
        send_b(4'd3, 2'b00);
        wait_accept();
        wait_idle();
        send_b(4'd4, 2'b00);
        send_b(4'd5, 2'b00);
        chk("t3_drain_outst", 64'(outst_cnt), 64'd0);
        chk("t3_drain_done", 64'(done_cnt), 64'd6);

        // Error response still counted.
        issue_cmd(4'd6, 32'h500, 4'd0, REGULAR, 32'h50);
        wait_idle();
        send_b(4'd6, 2'b10);
        chk("t4_slverr_err", 64'(err), 64'd1);
        chk("t4_slverr_done", 64'(done_cnt), 64'd7);
        chk("t4_slverr_outst", 64'(outst_cnt), 64'd0);

        // Unexpected B with nothing outstanding.
        apply_reset();
        send_b(4'd1, 2'b00);
        chk("t5_unexp_err", 64'(err), 64'd1);
        chk("t5_unexp_done", 64'(done_cnt), 64'd0);
        chk("t5_unexp_outst", 64'(outst_cnt), 64'd0);
        apply_reset();

        // Single-beat and maximum-length bursts, with data wrap.
        base = wlog.size();
        issue_cmd(4'd8, 32'h600, 4'd0, REGULAR, 32'hAA);
        wait_idle();
        chk("t6_len0_beats", 64'(wlog.size() - base), 64'd1);
        chk("t6_len0_data", 64'(wlog[base]), 64'hAB);
        chk("t6_len0_last", 64'(llog[base]), 64'd1);
        base = wlog.size();
        issue_cmd(4'd9, 32'h700, 4'd15, DIVERT, 32'hFFFF_FFF8);
        wait_idle();
        chk("t6_len15_beats", 64'(wlog.size() - base), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t6_len15_last", 64'(llog[base+i]), 64'(i == 15));
        end
        chk("t6_len15_first", 64'(wlog[base]), 64'hFFFF_FFF9);
        chk("t6_len15_wrap", 64'(wlog[base+15]), 64'h8);
        send_b(4'd8, 2'b00);
        send_b(4'd9, 2'b00);

        // Reset in the middle of a long burst.
        base = wlog.size();
        issue_cmd(4'd10, 32'h800, 4'd15, REGULAR, 32'h1000);
        for (int i = 0; i < 200 && wlog.size() < base + 7; i++) begin
            @(negedge clk);
            #2;
        end
        chk("t6_beat7_reached", 64'(wlog.size() >= base + 7), 64'd1);
        apply_reset();

`ifdef AXI_WR_BURST_GEN_ID_TRACK_EN
        issue_cmd(4'd3, 32'h900, 4'd1, BLOCK, 32'h0);
        wait_idle();
        issue_cmd(4'd2, 32'hA00, 4'd0, REGULAR, 32'h0);
        wait_idle();
        chk("t7_busy3", 64'(id_busy[3]), 64'd1);
        chk("t7_busy2", 64'(id_busy[2]), 64'd1);
        send_b(4'd5, 2'b00);
        chk("t7_badid_err", 64'(err), 64'd1);
        chk("t7_badid_outst", 64'(outst_cnt), 64'd2);
        send_b(4'd3, 2'b00);
        chk("t7_busy3_clear", 64'(id_busy[3]), 64'd0);
        chk("t7_busy2_held", 64'(id_busy[2]), 64'd1);
        chk("t7_outst", 64'(outst_cnt), 64'd1);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
